// File: rtl/router_pkg.sv
// Shared types and constants for the router scheduler slice.
package router_pkg;

    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = 32;
    localparam int MAX_PORTS = 16;

    // One held packet: destination output and its payload.
    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

endpackage

// File: rtl/router_scheduler_rr_arbiter.sv
// Round-robin arbiter for one output port. Grant is combinational; the
// rotating pointer advances to one past the winner on every grant.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int N = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              en,
    input  logic [N-1:0]      req,
    output logic              gnt_vld,
    output logic [ADDR_W-1:0] gnt_idx
);

    logic [ADDR_W-1:0] ptr_r;
    logic              hi_found_s;
    logic [ADDR_W-1:0] hi_idx_s;
    logic              lo_found_s;
    logic [ADDR_W-1:0] lo_idx_s;
    logic              gnt_vld_s;
    logic [ADDR_W-1:0] gnt_idx_s;

    // Lowest requester at or above the pointer, else lowest requester overall.
    always_comb begin
        hi_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_found_s = 1'b0;
        lo_idx_s   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_found_s = 1'b1;
                lo_idx_s   = ADDR_W'(j);
                if (ADDR_W'(j) >= ptr_r) begin
                    hi_found_s = 1'b1;
                    hi_idx_s   = ADDR_W'(j);
                end else begin
                    hi_found_s = hi_found_s;
                end
            end else begin
                lo_found_s = lo_found_s;
            end
        end
        if (en && hi_found_s) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = hi_idx_s;
        end else if (en && lo_found_s) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = lo_idx_s;
        end else begin
            gnt_vld_s = 1'b0;
            gnt_idx_s = '0;
        end
    end

    // Rotate the priority pointer past the granted requester.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (clear) begin
            ptr_r <= '0;
        end else if (gnt_vld_s) begin
            ptr_r <= (gnt_idx_s == ADDR_W'(N - 1)) ? '0 : gnt_idx_s + ADDR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt_vld = gnt_vld_s;
    assign gnt_idx = gnt_idx_s;

endmodule

// File: rtl/router_scheduler.sv
// Per-output round-robin scheduler: one holding slot per input, one arbiter
// per output, registered output pulses and saturating loss counters.
module router_scheduler
    import router_pkg::*;
#(
    parameter int NUM_IN  = 16,
    parameter int NUM_OUT = 16,
    parameter int DROP_W  = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic [NUM_IN-1:0]             in_vld,
    input  logic [ADDR_W*NUM_IN-1:0]      in_addr,
    input  logic [PAYLOAD_W*NUM_IN-1:0]   in_payload,
    output logic [NUM_IN-1:0]             in_busy,
    input  logic [NUM_OUT-1:0]            out_ready,
    output logic [NUM_OUT-1:0]            out_vld,
    output logic [PAYLOAD_W*NUM_OUT-1:0]  out_payload,
    output logic [ADDR_W*NUM_OUT-1:0]     out_src,
    output logic [DROP_W-1:0]             drop_cnt,
    output logic [DROP_W-1:0]             bad_addr_cnt
);

    localparam logic [ADDR_W:0] NUM_OUT_C = (ADDR_W + 1)'(NUM_OUT);
    localparam int              SUM_W     = DROP_W + ADDR_W + 1;

    packet_t                slot_pkt_r [NUM_IN];
    logic [NUM_IN-1:0]      slot_full_r;
    logic [NUM_IN-1:0]      req_s [NUM_OUT];
    logic                   gnt_vld_s [NUM_OUT];
    logic [ADDR_W-1:0]      gnt_idx_s [NUM_OUT];
    logic [PAYLOAD_W-1:0]   gnt_payload_s [NUM_OUT];
    logic [NUM_IN-1:0]      granted_s;
    logic [NUM_IN-1:0]      capture_s;
    logic [NUM_IN-1:0]      drop_s;
    logic [NUM_IN-1:0]      bad_s;
    logic [ADDR_W:0]        drop_inc_s;
    logic [ADDR_W:0]        bad_inc_s;
    logic [NUM_OUT-1:0]     out_vld_r;
    logic [PAYLOAD_W*NUM_OUT-1:0] out_payload_r;
    logic [ADDR_W*NUM_OUT-1:0]    out_src_r;
    logic [DROP_W-1:0]      drop_cnt_r;
    logic [DROP_W-1:0]      bad_addr_cnt_r;

    // Add a small increment to a counter, sticking at all-ones.
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] cnt,
                                                  input logic [ADDR_W:0]   inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'({DROP_W{1'b1}})) begin
            return {DROP_W{1'b1}};
        end else begin
            return sum[DROP_W-1:0];
        end
    endfunction

    // Decode held packets into per-output request vectors.
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                req_s[o][i] = slot_full_r[i] && (slot_pkt_r[i].addr == ADDR_W'(o));
            end
        end
    end

    genvar go;
    generate
        for (go = 0; go < NUM_OUT; go++) begin : g_arb
            rr_arbiter #(.N(NUM_IN)) u_arb (
                .clock   (clock),
                .reset_n (reset_n),
                .clear   (clear),
                .en      (out_ready[go]),
                .req     (req_s[go]),
                .gnt_vld (gnt_vld_s[go]),
                .gnt_idx (gnt_idx_s[go])
            );
        end
    endgenerate

    // Mark granted slots and select the winning payload for each output.
    always_comb begin
        granted_s = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            gnt_payload_s[o] = '0;
        end
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (gnt_vld_s[o] && (gnt_idx_s[o] == ADDR_W'(i))) begin
                    granted_s[i]     = 1'b1;
                    gnt_payload_s[o] = slot_pkt_r[i].payload;
                end else begin
                    granted_s[i] = granted_s[i];
                end
            end
        end
    end

    // Classify each arriving packet as captured, dropped or bad-addressed.
    always_comb begin
        drop_inc_s = '0;
        bad_inc_s  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            logic addr_ok_v;
            addr_ok_v    = {1'b0, in_addr[ADDR_W*i +: ADDR_W]} < NUM_OUT_C;
            capture_s[i] = in_vld[i] && addr_ok_v && (!slot_full_r[i] || granted_s[i]);
            drop_s[i]    = in_vld[i] && addr_ok_v && slot_full_r[i] && !granted_s[i];
            bad_s[i]     = in_vld[i] && !addr_ok_v;
            drop_inc_s   = drop_inc_s + (ADDR_W + 1)'(drop_s[i]);
            bad_inc_s    = bad_inc_s + (ADDR_W + 1)'(bad_s[i]);
        end
    end

    // Holding slots: capture wins over the same-edge grant release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_full_r <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                slot_pkt_r[i] <= '0;
            end
        end else if (clear) begin
            slot_full_r <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (capture_s[i]) begin
                    slot_full_r[i]        <= 1'b1;
                    slot_pkt_r[i].addr    <= in_addr[ADDR_W*i +: ADDR_W];
                    slot_pkt_r[i].payload <= in_payload[PAYLOAD_W*i +: PAYLOAD_W];
                end else if (granted_s[i]) begin
                    slot_full_r[i] <= 1'b0;
                end else begin
                    slot_full_r[i] <= slot_full_r[i];
                end
            end
        end
    end

    // Output registers: pulse on grant, hold payload and source otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_r     <= '0;
            out_payload_r <= '0;
            out_src_r     <= '0;
        end else if (clear) begin
            out_vld_r     <= '0;
            out_payload_r <= '0;
            out_src_r     <= '0;
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                out_vld_r[o] <= gnt_vld_s[o];
                if (gnt_vld_s[o]) begin
                    out_payload_r[PAYLOAD_W*o +: PAYLOAD_W] <= gnt_payload_s[o];
                    out_src_r[ADDR_W*o +: ADDR_W]           <= gnt_idx_s[o];
                end else begin
                    out_payload_r[PAYLOAD_W*o +: PAYLOAD_W] <= out_payload_r[PAYLOAD_W*o +: PAYLOAD_W];
                    out_src_r[ADDR_W*o +: ADDR_W]           <= out_src_r[ADDR_W*o +: ADDR_W];
                end
            end
        end
    end

    // Loss counters survive a flush and clear only on hard reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r     <= '0;
            bad_addr_cnt_r <= '0;
        end else if (clear) begin
            drop_cnt_r     <= drop_cnt_r;
            bad_addr_cnt_r <= bad_addr_cnt_r;
        end else begin
            drop_cnt_r     <= sat_add(drop_cnt_r, drop_inc_s);
            bad_addr_cnt_r <= sat_add(bad_addr_cnt_r, bad_inc_s);
        end
    end

    assign in_busy      = slot_full_r;
    assign out_vld      = out_vld_r;
    assign out_payload  = out_payload_r;
    assign out_src      = out_src_r;
    assign drop_cnt     = drop_cnt_r;
    assign bad_addr_cnt = bad_addr_cnt_r;

endmodule

// File: tb/tb_router_scheduler.sv
// Directed self-checking bench for router_scheduler (16 inputs, 8 outputs).
module tb_router_scheduler;

    localparam int NI = 16;
    localparam int NO = 8;
    localparam int DW = 8;

    logic            clock;
    logic            reset_n;
    logic            clear;
    logic [NI-1:0]   in_vld;
    logic [4*NI-1:0] in_addr;
    logic [32*NI-1:0] in_payload;
    logic [NI-1:0]   in_busy;
    logic [NO-1:0]   out_ready;
    logic [NO-1:0]   out_vld;
    logic [32*NO-1:0] out_payload;
    logic [4*NO-1:0] out_src;
    logic [DW-1:0]   drop_cnt;
    logic [DW-1:0]   bad_addr_cnt;

    int n_tests;
    int n_failed;

    router_scheduler #(.NUM_IN(NI), .NUM_OUT(NO), .DROP_W(DW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .in_vld       (in_vld),
        .in_addr      (in_addr),
        .in_payload   (in_payload),
        .in_busy      (in_busy),
        .out_ready    (out_ready),
        .out_vld      (out_vld),
        .out_payload  (out_payload),
        .out_src      (out_src),
        .drop_cnt     (drop_cnt),
        .bad_addr_cnt (bad_addr_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int i, input logic [3:0] a, input logic [31:0] p);
        in_vld[i]            = 1'b1;
        in_addr[4*i +: 4]    = a;
        in_payload[32*i +: 32] = p;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        clear      = 1'b0;
        in_vld     = '0;
        in_addr    = '0;
        in_payload = '0;
        out_ready  = '1;
        #3;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        clear      = 1'b0;
        in_vld     = '0;
        in_addr    = '0;
        in_payload = '0;
        out_ready  = '1;
        #2;
        n_tests++;
        if ({in_busy, out_vld, out_src, drop_cnt, bad_addr_cnt} !== '0 || out_payload !== '0) begin
            n_failed++;
            $display("FAIL reset_state: busy=%h vld=%h src=%h drop=%0d bad=%0d required all zero",
                     in_busy, out_vld, out_src, drop_cnt, bad_addr_cnt);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        send(3, 4'd5, 32'hDEADBEEF);
        step();
        in_vld = '0;
        n_tests++;
        if (in_busy !== 16'h0008 || out_vld !== 8'h00) begin
            n_failed++;
            $display("FAIL single_capture: busy=%h vld=%h required busy=0008 vld=00", in_busy, out_vld);
        end
        step();
        n_tests++;
        if (out_vld !== 8'h20 || out_payload[5*32 +: 32] !== 32'hDEADBEEF || out_src[5*4 +: 4] !== 4'd3) begin
            n_failed++;
            $display("FAIL single_deliver: vld=%h payload=%h src=%0d required 20 deadbeef 3",
                     out_vld, out_payload[5*32 +: 32], out_src[5*4 +: 4]);
        end
        n_tests++;
        if (in_busy !== 16'h0000) begin
            n_failed++;
            $display("FAIL single_release: busy=%h required 0000", in_busy);
        end
        step();
        n_tests++;
        if (out_vld !== 8'h00) begin
            n_failed++;
            $display("FAIL single_pulse: vld=%h required 00", out_vld);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_src [3];
        exp_src[0] = 4'd0;
        exp_src[1] = 4'd2;
        exp_src[2] = 4'd7;
        do_reset();
        for (int burst = 0; burst < 2; burst++) begin
            send(0, 4'd1, 32'h0000_00A0);
            send(2, 4'd1, 32'h0000_00A2);
            send(7, 4'd1, 32'h0000_00A7);
            step();
            in_vld = '0;
            n_tests++;
            if (in_busy !== 16'h0085) begin
                n_failed++;
                $display("FAIL rr_capture: burst=%0d busy=%h required 0085", burst, in_busy);
            end
            for (int k = 0; k < 3; k++) begin
                step();
                n_tests++;
                if (out_vld !== 8'h02 || out_src[4 +: 4] !== exp_src[k] ||
                    out_payload[32 +: 32] !== {24'h0, 4'hA, exp_src[k]}) begin
                    n_failed++;
                    $display("FAIL rr_order: burst=%0d slot=%0d vld=%h src=%0d payload=%h required vld=02 src=%0d",
                             burst, k, out_vld, out_src[4 +: 4], out_payload[32 +: 32], exp_src[k]);
                end
            end
            step();
            n_tests++;
            if (out_vld !== 8'h00 || in_busy !== 16'h0000) begin
                n_failed++;
                $display("FAIL rr_drain: burst=%0d vld=%h busy=%h required 00 0000", burst, out_vld, in_busy);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 8'hEF;
        send(1, 4'd4, 32'h1111_0001);
        step();
        in_vld = '0;
        step();
        n_tests++;
        if (in_busy !== 16'h0002 || out_vld !== 8'h00) begin
            n_failed++;
            $display("FAIL bp_hold: busy=%h vld=%h required 0002 00", in_busy, out_vld);
        end
        send(1, 4'd4, 32'h1111_0002);
        step();
        in_vld = '0;
        n_tests++;
        if (drop_cnt !== 8'd1 || in_busy !== 16'h0002) begin
            n_failed++;
            $display("FAIL bp_drop: drop=%0d busy=%h required 1 0002", drop_cnt, in_busy);
        end
        send(1, 4'd12, 32'h1111_0003);
        step();
        in_vld = '0;
        n_tests++;
        if (bad_addr_cnt !== 8'd1 || drop_cnt !== 8'd1) begin
            n_failed++;
            $display("FAIL bp_bad_over_full: bad=%0d drop=%0d required 1 1", bad_addr_cnt, drop_cnt);
        end
        out_ready = '1;
        step();
        n_tests++;
        if (out_vld !== 8'h10 || out_payload[4*32 +: 32] !== 32'h1111_0001 || out_src[4*4 +: 4] !== 4'd1) begin
            n_failed++;
            $display("FAIL bp_release: vld=%h payload=%h src=%0d required 10 11110001 1",
                     out_vld, out_payload[4*32 +: 32], out_src[4*4 +: 4]);
        end
        step();
        n_tests++;
        if (out_vld !== 8'h00 || in_busy !== 16'h0000) begin
            n_failed++;
            $display("FAIL bp_once: vld=%h busy=%h required 00 0000", out_vld, in_busy);
        end
    endtask

    task automatic test_bad_addr();
        do_reset();
        send(0, 4'd12, 32'h0000_0005);
        step();
        in_vld = '0;
        n_tests++;
        if (in_busy !== 16'h0000 || bad_addr_cnt !== 8'd1 || out_vld !== 8'h00 || drop_cnt !== 8'd0) begin
            n_failed++;
            $display("FAIL bad_single: busy=%h bad=%0d vld=%h drop=%0d required 0000 1 00 0",
                     in_busy, bad_addr_cnt, out_vld, drop_cnt);
        end
        send(0, 4'd8, 32'h0000_0006);
        repeat (253) step();
        n_tests++;
        if (bad_addr_cnt !== 8'd254) begin
            n_failed++;
            $display("FAIL bad_count_254: bad=%0d required 254", bad_addr_cnt);
        end
        repeat (47) step();
        in_vld = '0;
        n_tests++;
        if (bad_addr_cnt !== 8'd255 || in_busy !== 16'h0000) begin
            n_failed++;
            $display("FAIL bad_saturate: bad=%0d busy=%h required 255 0000", bad_addr_cnt, in_busy);
        end
    endtask

    task automatic test_clear_reset();
        do_reset();
        out_ready = '0;
        for (int i = 0; i < 4; i++) send(i, 4'(i), 32'h0000_00C0 + 32'(i));
        step();
        in_vld = '0;
        send(0, 4'd0, 32'h0000_00FF);
        send(5, 4'd9, 32'h0000_0055);
        step();
        in_vld = '0;
        n_tests++;
        if (in_busy !== 16'h000F || drop_cnt !== 8'd1 || bad_addr_cnt !== 8'd1) begin
            n_failed++;
            $display("FAIL clr_setup: busy=%h drop=%0d bad=%0d required 000f 1 1", in_busy, drop_cnt, bad_addr_cnt);
        end
        clear     = 1'b1;
        out_ready = '1;
        send(4, 4'd0, 32'h0000_0044);
        step();
        clear  = 1'b0;
        in_vld = '0;
        n_tests++;
        if (in_busy !== 16'h0000 || out_vld !== 8'h00 || drop_cnt !== 8'd1 || bad_addr_cnt !== 8'd1) begin
            n_failed++;
            $display("FAIL clr_flush: busy=%h vld=%h drop=%0d bad=%0d required 0000 00 1 1",
                     in_busy, out_vld, drop_cnt, bad_addr_cnt);
        end
        step();
        n_tests++;
        if (out_vld !== 8'h00) begin
            n_failed++;
            $display("FAIL clr_no_leftover: vld=%h required 00", out_vld);
        end
        out_ready = '0;
        for (int i = 0; i < 4; i++) send(i, 4'(i), 32'h0000_00D0 + 32'(i));
        step();
        in_vld    = '0;
        out_ready = 8'h01;
        step();
        out_ready = '0;
        step();
        n_tests++;
        if (out_vld !== 8'h00 || out_payload[0 +: 32] !== 32'h0000_00D0 || in_busy !== 16'h000E) begin
            n_failed++;
            $display("FAIL clr_hold: vld=%h payload=%h busy=%h required 00 000000d0 000e",
                     out_vld, out_payload[0 +: 32], in_busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({in_busy, out_vld, out_src, drop_cnt, bad_addr_cnt} !== '0 || out_payload !== '0) begin
            n_failed++;
            $display("FAIL async_reset: busy=%h vld=%h payload0=%h drop=%0d bad=%0d required all zero",
                     in_busy, out_vld, out_payload[0 +: 32], drop_cnt, bad_addr_cnt);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = '1;
        for (int k = 0; k < 6; k++) begin
            send(6, 4'd2, 32'h0000_B000 + 32'(k));
            step();
            if (k > 0) begin
                n_tests++;
                if (out_vld !== 8'h04 || out_payload[2*32 +: 32] !== 32'h0000_B000 + 32'(k - 1) ||
                    out_src[2*4 +: 4] !== 4'd6) begin
                    n_failed++;
                    $display("FAIL b2b_deliver: k=%0d vld=%h payload=%h src=%0d required 04 %h 6",
                             k, out_vld, out_payload[2*32 +: 32], out_src[2*4 +: 4], 32'h0000_B000 + 32'(k - 1));
                end
            end
        end
        in_vld = '0;
        step();
        n_tests++;
        if (out_vld !== 8'h04 || out_payload[2*32 +: 32] !== 32'h0000_B005) begin
            n_failed++;
            $display("FAIL b2b_last: vld=%h payload=%h required 04 0000b005", out_vld, out_payload[2*32 +: 32]);
        end
        step();
        n_tests++;
        if (out_vld !== 8'h00 || drop_cnt !== 8'd0 || in_busy !== 16'h0000) begin
            n_failed++;
            $display("FAIL b2b_no_drop: vld=%h drop=%0d busy=%h required 00 0 0000", out_vld, drop_cnt, in_busy);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_bad_addr();
        test_clear_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
